// File: rtl/pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// pwm_fade_ctrl : period-synchronised duty sequencer (static / breathe / chase)
// Rev 1.0
// ============================================================================
module pwm_fade_ctrl #(
  parameter int CH   = 4,
  parameter int DW   = 8,
  parameter int STEP = 4,
  parameter int HOLD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DW-1:0]    static_duty,
  input  logic             period_end,
  output logic [CH*DW-1:0] duty,
  output logic             duty_valid,
  output logic [1:0]       state
);

  localparam int PW = (CH > 1) ? $clog2(CH) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [DW-1:0] C_MAX       = {DW{1'b1}};
  localparam logic [DW-1:0] C_STEP      = DW'(STEP);
  localparam logic [DW:0]   C_STEP_WIDE = (DW+1)'(STEP);
  localparam logic [HW-1:0] C_HOLD_LAST = HW'(HOLD - 1);
  localparam logic [PW-1:0] C_PTR_LAST  = PW'(CH - 1);
  localparam logic [1:0]    C_MODE_BREATHE = 2'd1;
  localparam logic [1:0]    C_MODE_CHASE   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STATIC = 2'd1,
    ST_UP     = 2'd2,
    ST_DOWN   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     level_q, level_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [1:0]        cur_mode_q, cur_mode_d;
  logic [CH*DW-1:0]  duty_q, duty_d;
  logic              duty_valid_q, duty_valid_d;

  logic              w_update;
  logic              w_ramp_mode;
  logic              w_chase;
  logic [DW:0]       w_level_up;
  logic [PW-1:0]     w_ptr_next;
  logic [CH*DW-1:0]  w_upd_duty;

  assign w_update    = en && period_end && (hold_cnt_q == C_HOLD_LAST);
  assign w_ramp_mode = (mode == C_MODE_BREATHE) || (mode == C_MODE_CHASE);
  assign w_chase     = (mode == C_MODE_CHASE);
  assign w_level_up  = {1'b0, level_q} + C_STEP_WIDE;
  assign w_ptr_next  = (ptr_q == C_PTR_LAST) ? '0 : ptr_q + PW'(1);

  // Ramp/level sequencing; duty is derived from the post-update level and ptr.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    cur_mode_d = cur_mode_q;
    if (!en) begin
      state_d    = ST_IDLE;
      level_d    = '0;
      ptr_d      = '0;
      hold_cnt_d = '0;
    end else if (period_end) begin
      if (w_update) begin
        hold_cnt_d = '0;
        cur_mode_d = mode;
        if (!w_ramp_mode) begin
          level_d = static_duty;
          state_d = ST_STATIC;
        end else if ((mode != cur_mode_q) || (state_q == ST_IDLE) ||
                     (state_q == ST_STATIC)) begin
          level_d = C_STEP;
          ptr_d   = '0;
          state_d = ST_UP;
        end else if (state_q == ST_UP) begin
          if (w_level_up >= {1'b0, C_MAX}) begin
            level_d = C_MAX;
            state_d = ST_DOWN;
          end else begin
            level_d = w_level_up[DW-1:0];
          end
        end else begin
          if ({1'b0, level_q} <= C_STEP_WIDE) begin
            level_d = '0;
            state_d = ST_UP;
            if (w_chase) begin
              ptr_d = w_ptr_next;
            end
          end else begin
            level_d = level_q - C_STEP;
          end
        end
      end else begin
        hold_cnt_d = hold_cnt_q + HW'(1);
      end
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign w_upd_duty[i*DW +: DW] = (!w_chase || (ptr_d == PW'(i))) ? level_d : '0;
  end

  always_comb begin
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    if (!en) begin
      duty_d       = '0;
      duty_valid_d = |duty_q;
    end else if (w_update) begin
      duty_d       = w_upd_duty;
      duty_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      level_q      <= '0;
      ptr_q        <= '0;
      hold_cnt_q   <= '0;
      cur_mode_q   <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      ptr_q        <= ptr_d;
      hold_cnt_q   <= hold_cnt_d;
      cur_mode_q   <= cur_mode_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
    end
  end

  assign duty       = duty_q;
  assign duty_valid = duty_valid_q;
  assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pwm_fade_ctrl : directed + random checks of three pwm_fade_ctrl configs
// Rev 1.0
// ============================================================================
module tb_pwm_fade_ctrl;

  localparam int NI   = 3;
  localparam int MAXV = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        period_end;
  logic [1:0]  mode;
  logic [7:0]  static_duty;

  logic [31:0] duty_a, duty_b;
  logic [23:0] duty_c;
  logic        dv_a, dv_b, dv_c;
  logic [1:0]  st_a, st_b, st_c;

  always #5 clk = ~clk;

  pwm_fade_ctrl #(.CH(4), .DW(8), .STEP(64), .HOLD(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .static_duty(static_duty),
    .period_end(period_end), .duty(duty_a), .duty_valid(dv_a), .state(st_a));

  pwm_fade_ctrl #(.CH(4), .DW(8), .STEP(128), .HOLD(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .static_duty(static_duty),
    .period_end(period_end), .duty(duty_b), .duty_valid(dv_b), .state(st_b));

  pwm_fade_ctrl #(.CH(3), .DW(8), .STEP(40), .HOLD(3)) u_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .static_duty(static_duty),
    .period_end(period_end), .duty(duty_c), .duty_valid(dv_c), .state(st_c));

  int p_ch[NI]   = '{4, 4, 3};
  int p_step[NI] = '{64, 128, 40};
  int p_hold[NI] = '{1, 1, 3};

  // Reference state: state codes 0 idle, 1 static, 2 rising, 3 falling.
  int m_level[NI];
  int m_ptr[NI];
  int m_hold[NI];
  int m_cur[NI];
  int m_st[NI];
  int m_dv[NI];
  int m_duty[NI][4];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_duty(input int k);
    case (k)
      0:       return duty_a;
      1:       return duty_b;
      default: return {8'h00, duty_c};
    endcase
  endfunction

  function automatic logic [31:0] obs_dv(input int k);
    case (k)
      0:       return {31'd0, dv_a};
      1:       return {31'd0, dv_b};
      default: return {31'd0, dv_c};
    endcase
  endfunction

  function automatic logic [31:0] obs_st(input int k);
    case (k)
      0:       return {30'd0, st_a};
      1:       return {30'd0, st_b};
      default: return {30'd0, st_c};
    endcase
  endfunction

  function automatic logic [31:0] exp_duty(input int k);
    logic [31:0] e;
    e = '0;
    for (int c = 0; c < p_ch[k]; c++) e[8*c +: 8] = 8'(m_duty[k][c]);
    return e;
  endfunction

  task automatic model_zero(input int k);
    m_level[k] = 0;
    m_ptr[k]   = 0;
    m_hold[k]  = 0;
    m_st[k]    = 0;
    for (int c = 0; c < 4; c++) m_duty[k][c] = 0;
  endtask

  task automatic model_update(input int k);
    int m;
    m = int'(mode);
    if (m == 0 || m == 3) begin
      m_level[k] = int'(static_duty);
      m_st[k]    = 1;
    end else if (m != m_cur[k] || m_st[k] < 2) begin
      m_level[k] = p_step[k];
      m_ptr[k]   = 0;
      m_st[k]    = 2;
    end else if (m_st[k] == 2) begin
      m_level[k] = m_level[k] + p_step[k];
      if (m_level[k] >= MAXV) begin
        m_level[k] = MAXV;
        m_st[k]    = 3;
      end
    end else begin
      m_level[k] = m_level[k] - p_step[k];
      if (m_level[k] <= 0) begin
        m_level[k] = 0;
        m_st[k]    = 2;
        if (m == 2) m_ptr[k] = (m_ptr[k] + 1) % p_ch[k];
      end
    end
    for (int c = 0; c < 4; c++)
      m_duty[k][c] = (c < p_ch[k] && (m != 2 || c == m_ptr[k])) ? m_level[k] : 0;
    m_cur[k] = m;
  endtask

  task automatic model_clock();
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        model_zero(k);
        m_cur[k] = 0;
        m_dv[k]  = 0;
      end else if (!en) begin
        m_dv[k] = (exp_duty(k) != 0) ? 1 : 0;
        model_zero(k);
      end else if (period_end && m_hold[k] == p_hold[k] - 1) begin
        m_hold[k] = 0;
        model_update(k);
        m_dv[k] = 1;
      end else begin
        if (period_end) m_hold[k]++;
        m_dv[k] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("duty[%0d]", k), obs_duty(k), exp_duty(k));
      check($sformatf("duty_valid[%0d]", k), obs_dv(k), 32'(m_dv[k]));
      check($sformatf("state[%0d]", k), obs_st(k), 32'(m_st[k]));
    end
  endtask

  task automatic pulse();
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
    tick();
  endtask

  int breathe_lvl[9] = '{64, 128, 192, 255, 191, 127, 63, 0, 64};
  int breathe_st[9]  = '{2, 2, 2, 3, 3, 3, 3, 2, 2};
  logic [31:0] chase_b[8] = '{32'h80, 32'hFF, 32'h7F, 32'h0,
                              32'h8000, 32'hFF00, 32'h7F00, 32'h0};

  initial begin
    rst = 1'b1; en = 1'b0; period_end = 1'b0; mode = 2'd0; static_duty = 8'h00;
    for (int k = 0; k < NI; k++) begin
      model_zero(k);
      m_cur[k] = 0;
      m_dv[k]  = 0;
    end
    tick();
    tick();
    check("reset_duty_a", duty_a, 32'h0);
    check("reset_state_a", {30'd0, st_a}, 32'd0);
    rst = 1'b0;
    tick();

    // Breathe ramp, plus the divide-by-3 hold on instance C.
    en = 1'b1; mode = 2'd1;
    for (int i = 0; i < 9; i++) begin
      period_end = 1'b1;
      tick();
      check("breathe_lvl", duty_a, {4{8'(breathe_lvl[i])}});
      check("breathe_st", {30'd0, st_a}, 32'(breathe_st[i]));
      check("hold_dv_upd", {31'd0, dv_c}, ((i % 3) == 2) ? 32'd1 : 32'd0);
      period_end = 1'b0;
      tick();
      check("hold_dv_idle", {31'd0, dv_c}, 32'd0);
    end

    // Chase on instance B, through the ptr wrap.
    mode = 2'd2;
    for (int i = 0; i < 17; i++) begin
      pulse();
      if (i < 8) check("chase_seq", duty_b, chase_b[i]);
    end
    check("chase_wrap", duty_b, 32'h80);

    // Static level, then a mode switch between updates.
    mode = 2'd0; static_duty = 8'h5A;
    pulse();
    check("static_duty", duty_a, 32'h5A5A5A5A);
    check("static_state", {30'd0, st_a}, 32'd1);
    mode = 2'd1;
    tick(); tick(); tick();
    check("switch_hold", duty_a, 32'h5A5A5A5A);
    pulse();
    check("switch_restart", duty_a, 32'h40404040);
    check("switch_state", {30'd0, st_a}, 32'd2);

    // Disable mid-ramp with a coincident period_end, then re-enable.
    pulse(); pulse();
    en = 1'b0; period_end = 1'b1;
    tick();
    check("dis_duty", duty_a, 32'h0);
    check("dis_state", {30'd0, st_a}, 32'd0);
    check("dis_dv", {31'd0, dv_a}, 32'd1);
    period_end = 1'b0;
    tick();
    check("dis_dv_once", {31'd0, dv_a}, 32'd0);
    pulse(); pulse();
    check("dis_static", duty_a, 32'h0);
    en = 1'b1;
    pulse();
    check("reen_restart", duty_a, 32'h40404040);

    // Async reset while falling.
    pulse(); pulse(); pulse(); pulse();
    check("pre_rst_down", {30'd0, st_a}, 32'd3);
    #2 rst = 1'b1;
    #1;
    check("arst_duty_a", duty_a, 32'h0);
    check("arst_duty_c", {8'h0, duty_c}, 32'h0);
    check("arst_state_a", {30'd0, st_a}, 32'd0);
    check("arst_dv_a", {31'd0, dv_a}, 32'd0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    pulse();
    check("post_rst_fresh", duty_a, 32'h40404040);
    check("post_rst_state", {30'd0, st_a}, 32'd2);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      en         = ($urandom_range(0, 149) != 0);
      period_end = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 79) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) static_duty = 8'($urandom);
      rst        = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
